// File: rtl/riscv_ctrl_pkg.sv
`default_nettype none
// =============================================================================
// Module   : riscv_ctrl_pkg
// Purpose  : Shared state codes, opcodes and control encodings for the
//            multicycle RV32I control path.
// Revision : 1.0 - initial release
// =============================================================================
package riscv_ctrl_pkg;

    localparam logic [3:0] S_FETCH    = 4'd0;
    localparam logic [3:0] S_DECODE   = 4'd1;
    localparam logic [3:0] S_MEMADR   = 4'd2;
    localparam logic [3:0] S_MEMREAD  = 4'd3;
    localparam logic [3:0] S_MEMWB    = 4'd4;
    localparam logic [3:0] S_MEMWRITE = 4'd5;
    localparam logic [3:0] S_EXECUTER = 4'd6;
    localparam logic [3:0] S_EXECUTEI = 4'd7;
    localparam logic [3:0] S_ALUWB    = 4'd8;
    localparam logic [3:0] S_JAL      = 4'd9;
    localparam logic [3:0] S_BEQ      = 4'd10;

    localparam logic [6:0] OP_LW  = 7'b0000011;
    localparam logic [6:0] OP_SW  = 7'b0100011;
    localparam logic [6:0] OP_R   = 7'b0110011;
    localparam logic [6:0] OP_I   = 7'b0010011;
    localparam logic [6:0] OP_BEQ = 7'b1100011;
    localparam logic [6:0] OP_JAL = 7'b1101111;

    typedef enum logic [1:0] {
        ALUOP_ADD   = 2'b00,
        ALUOP_SUB   = 2'b01,
        ALUOP_FUNCT = 2'b10
    } aluop_e;

    typedef enum logic [1:0] {
        SRCA_PC    = 2'b00,
        SRCA_OLDPC = 2'b01,
        SRCA_RS1   = 2'b10
    } srca_e;

    typedef enum logic [1:0] {
        SRCB_RS2  = 2'b00,
        SRCB_IMM  = 2'b01,
        SRCB_FOUR = 2'b10
    } srcb_e;

    typedef enum logic [1:0] {
        RES_ALUOUT    = 2'b00,
        RES_DATA      = 2'b01,
        RES_ALURESULT = 2'b10
    } ressrc_e;

    // mem_gated marks strobes that only fire on the mem_ready cycle (FETCH).
    typedef struct packed {
        aluop_e  alu_op;
        srca_e   src_a;
        srcb_e   src_b;
        ressrc_e res_src;
        logic    adr_src;
        logic    ir_write;
        logic    pc_update;
        logic    branch;
        logic    reg_write;
        logic    mem_write;
        logic    mem_gated;
    } ctrl_t;

    localparam ctrl_t CTRL_IDLE = '0;

endpackage
`default_nettype wire

// File: rtl/main_fsm_outdec.sv
`default_nettype none
// =============================================================================
// Module   : main_fsm_outdec
// Purpose  : Combinational decode of the FSM state into the control word.
// Revision : 1.0 - initial release
// =============================================================================
module main_fsm_outdec
    import riscv_ctrl_pkg::*;
#(
    parameter int STATE_W = 4
) (
    input  logic [STATE_W-1:0] state_i,
    output ctrl_t              ctrl_o
);

    always_comb begin
        ctrl_o = CTRL_IDLE;
        case (state_i)
            STATE_W'(S_FETCH): begin
                ctrl_o.src_b     = SRCB_FOUR;
                ctrl_o.res_src   = RES_ALURESULT;
                ctrl_o.ir_write  = 1'b1;
                ctrl_o.pc_update = 1'b1;
                ctrl_o.mem_gated = 1'b1;
            end
            STATE_W'(S_DECODE): begin
                ctrl_o.src_a = SRCA_OLDPC;
                ctrl_o.src_b = SRCB_IMM;
            end
            STATE_W'(S_MEMADR): begin
                ctrl_o.src_a = SRCA_RS1;
                ctrl_o.src_b = SRCB_IMM;
            end
            STATE_W'(S_MEMREAD): ctrl_o.adr_src = 1'b1;
            STATE_W'(S_MEMWB): begin
                ctrl_o.res_src   = RES_DATA;
                ctrl_o.reg_write = 1'b1;
            end
            STATE_W'(S_MEMWRITE): begin
                ctrl_o.adr_src   = 1'b1;
                ctrl_o.mem_write = 1'b1;
            end
            STATE_W'(S_EXECUTER): begin
                ctrl_o.src_a  = SRCA_RS1;
                ctrl_o.alu_op = ALUOP_FUNCT;
            end
            STATE_W'(S_EXECUTEI): begin
                ctrl_o.src_a  = SRCA_RS1;
                ctrl_o.src_b  = SRCB_IMM;
                ctrl_o.alu_op = ALUOP_FUNCT;
            end
            STATE_W'(S_ALUWB): ctrl_o.reg_write = 1'b1;
            STATE_W'(S_JAL): begin
                ctrl_o.src_a     = SRCA_OLDPC;
                ctrl_o.src_b     = SRCB_FOUR;
                ctrl_o.pc_update = 1'b1;
            end
            STATE_W'(S_BEQ): begin
                ctrl_o.src_a  = SRCA_RS1;
                ctrl_o.alu_op = ALUOP_SUB;
                ctrl_o.branch = 1'b1;
            end
            default: ctrl_o = CTRL_IDLE;
        endcase
    end

endmodule
`default_nettype wire

// File: rtl/multicycle_main_fsm.sv
`default_nettype none
// =============================================================================
// Module   : multicycle_main_fsm
// Purpose  : Main control FSM of the multicycle RV32I datapath.
// Revision : 1.0 - initial release
// =============================================================================
module multicycle_main_fsm
    import riscv_ctrl_pkg::*;
#(
    parameter int STATE_W = 4
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic [6:0]         opcode,
    input  logic               zero,
    input  logic               mem_ready,
    output logic [1:0]         ALUOp,
    output logic [1:0]         ALUSrcA,
    output logic [1:0]         ALUSrcB,
    output logic [1:0]         ResultSrc,
    output logic               AdrSrc,
    output logic               IRWrite,
    output logic               PCWrite,
    output logic               RegWrite,
    output logic               MemWrite,
    output logic               illegal_instr,
    output logic [STATE_W-1:0] state_o
);

    logic [STATE_W-1:0] state_q;
    logic [STATE_W-1:0] state_d;
    logic               w_illegal;
    logic               w_ready_ok;
    ctrl_t              w_ctrl;

    always_comb begin
        state_d   = STATE_W'(S_FETCH);
        w_illegal = 1'b0;
        case (state_q)
            STATE_W'(S_FETCH):
                state_d = mem_ready ? STATE_W'(S_DECODE) : STATE_W'(S_FETCH);
            STATE_W'(S_DECODE): begin
                case (opcode)
                    OP_LW, OP_SW: state_d = STATE_W'(S_MEMADR);
                    OP_R:         state_d = STATE_W'(S_EXECUTER);
                    OP_I:         state_d = STATE_W'(S_EXECUTEI);
                    OP_BEQ:       state_d = STATE_W'(S_BEQ);
                    OP_JAL:       state_d = STATE_W'(S_JAL);
                    default: begin
                        state_d   = STATE_W'(S_FETCH);
                        w_illegal = 1'b1;
                    end
                endcase
            end
            STATE_W'(S_MEMADR):
                state_d = (opcode == OP_LW) ? STATE_W'(S_MEMREAD) : STATE_W'(S_MEMWRITE);
            STATE_W'(S_MEMREAD):
                state_d = mem_ready ? STATE_W'(S_MEMWB) : STATE_W'(S_MEMREAD);
            STATE_W'(S_MEMWRITE):
                state_d = mem_ready ? STATE_W'(S_FETCH) : STATE_W'(S_MEMWRITE);
            STATE_W'(S_EXECUTER), STATE_W'(S_EXECUTEI), STATE_W'(S_JAL):
                state_d = STATE_W'(S_ALUWB);
            default: state_d = STATE_W'(S_FETCH);
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= STATE_W'(S_FETCH);
        end else begin
            state_q <= state_d;
        end
    end

    main_fsm_outdec #(
        .STATE_W (STATE_W)
    ) u_outdec (
        .state_i (state_q),
        .ctrl_o  (w_ctrl)
    );

    // Every write strobe is ANDed with rst_n so none can rise while reset is held.
    assign w_ready_ok    = ~w_ctrl.mem_gated | mem_ready;
    assign IRWrite       = rst_n & w_ctrl.ir_write & w_ready_ok;
    assign PCWrite       = rst_n & ((w_ctrl.pc_update & w_ready_ok) | (w_ctrl.branch & zero));
    assign RegWrite      = rst_n & w_ctrl.reg_write;
    assign MemWrite      = rst_n & w_ctrl.mem_write;
    assign illegal_instr = rst_n & w_illegal;

    assign ALUOp     = w_ctrl.alu_op;
    assign ALUSrcA   = w_ctrl.src_a;
    assign ALUSrcB   = w_ctrl.src_b;
    assign ResultSrc = w_ctrl.res_src;
    assign AdrSrc    = w_ctrl.adr_src;
    assign state_o   = state_q;

endmodule
`default_nettype wire

// File: tb/tb_multicycle_main_fsm.sv
`default_nettype none
// =============================================================================
// Module   : tb_multicycle_main_fsm
// Purpose  : Self-checking bench for multicycle_main_fsm.
// Revision : 1.0 - initial release
// =============================================================================
module tb_multicycle_main_fsm;
    import riscv_ctrl_pkg::*;

    typedef struct packed {
        logic [3:0] st;
        logic       mr;
        logic       z;
        logic [6:0] op;
        logic [1:0] aop;
        logic [1:0] sa;
        logic [1:0] sb;
        logic [1:0] rs;
        logic       adr;
        logic       irw;
        logic       pcw;
        logic       rw;
        logic       mw;
        logic       ill;
    } cyc_t;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic [6:0] opcode = 7'd0;
    logic       zero = 1'b0;
    logic       mem_ready = 1'b1;
    logic [1:0] ALUOp, ALUSrcA, ALUSrcB, ResultSrc;
    logic       AdrSrc, IRWrite, PCWrite, RegWrite, MemWrite, illegal_instr;
    logic [3:0] state_o;

    int checks = 0;
    int failures = 0;
    int n_mw, n_rw, n_pcw, n_ill;
    cyc_t q[$];

    multicycle_main_fsm #(.STATE_W(4)) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .opcode        (opcode),
        .zero          (zero),
        .mem_ready     (mem_ready),
        .ALUOp         (ALUOp),
        .ALUSrcA       (ALUSrcA),
        .ALUSrcB       (ALUSrcB),
        .ResultSrc     (ResultSrc),
        .AdrSrc        (AdrSrc),
        .IRWrite       (IRWrite),
        .PCWrite       (PCWrite),
        .RegWrite      (RegWrite),
        .MemWrite      (MemWrite),
        .illegal_instr (illegal_instr),
        .state_o       (state_o)
    );

    always #5 clk = ~clk;

    // Expected control word for one cycle, straight from the per-state rules.
    function automatic cyc_t mk(input logic [3:0] st, input logic mr, input logic z,
                                input logic [6:0] op);
        cyc_t c;
        c = '0;
        c.st = st; c.mr = mr; c.z = z; c.op = op;
        if (st == S_FETCH)    begin c.sb = 2'b10; c.rs = 2'b10; c.irw = mr; c.pcw = mr; end
        if (st == S_DECODE)   begin c.sa = 2'b01; c.sb = 2'b01;
            c.ill = !(op inside {7'b0000011, 7'b0100011, 7'b0110011, 7'b0010011,
                                 7'b1100011, 7'b1101111}); end
        if (st == S_MEMADR)   begin c.sa = 2'b10; c.sb = 2'b01; end
        if (st == S_MEMREAD)  c.adr = 1'b1;
        if (st == S_MEMWB)    begin c.rs = 2'b01; c.rw = 1'b1; end
        if (st == S_MEMWRITE) begin c.adr = 1'b1; c.mw = 1'b1; end
        if (st == S_EXECUTER) begin c.sa = 2'b10; c.aop = 2'b10; end
        if (st == S_EXECUTEI) begin c.sa = 2'b10; c.sb = 2'b01; c.aop = 2'b10; end
        if (st == S_ALUWB)    c.rw = 1'b1;
        if (st == S_JAL)      begin c.sa = 2'b01; c.sb = 2'b10; c.pcw = 1'b1; end
        if (st == S_BEQ)      begin c.sa = 2'b10; c.aop = 2'b01; c.pcw = z; end
        return c;
    endfunction

    // Cycle-by-cycle expectation for one instruction: fs fetch stalls, ms memory stalls,
    // ign is the mem_ready value driven in states where it must be ignored.
    task automatic build(input logic [6:0] op, input logic z, input int fs, input int ms,
                         input logic ign);
        q.delete();
        repeat (fs) q.push_back(mk(S_FETCH, 1'b0, z, op));
        q.push_back(mk(S_FETCH, 1'b1, z, op));
        q.push_back(mk(S_DECODE, ign, z, op));
        case (op)
            7'b0000011: begin
                q.push_back(mk(S_MEMADR, ign, z, op));
                repeat (ms) q.push_back(mk(S_MEMREAD, 1'b0, z, op));
                q.push_back(mk(S_MEMREAD, 1'b1, z, op));
                q.push_back(mk(S_MEMWB, ign, z, op));
            end
            7'b0100011: begin
                q.push_back(mk(S_MEMADR, ign, z, op));
                repeat (ms) q.push_back(mk(S_MEMWRITE, 1'b0, z, op));
                q.push_back(mk(S_MEMWRITE, 1'b1, z, op));
            end
            7'b0110011: begin q.push_back(mk(S_EXECUTER, ign, z, op)); q.push_back(mk(S_ALUWB, ign, z, op)); end
            7'b0010011: begin q.push_back(mk(S_EXECUTEI, ign, z, op)); q.push_back(mk(S_ALUWB, ign, z, op)); end
            7'b1101111: begin q.push_back(mk(S_JAL, ign, z, op)); q.push_back(mk(S_ALUWB, ign, z, op)); end
            7'b1100011: q.push_back(mk(S_BEQ, ign, z, op));
            default: ;
        endcase
    endtask

    task automatic check_now(input cyc_t e, input string tag);
        checks++;
        n_mw  += int'(MemWrite);
        n_rw  += int'(RegWrite);
        n_pcw += int'(PCWrite);
        n_ill += int'(illegal_instr);
        if ({state_o, ALUOp, ALUSrcA, ALUSrcB, ResultSrc, AdrSrc, IRWrite, PCWrite, RegWrite,
             MemWrite, illegal_instr} !== {e.st, e.aop, e.sa, e.sb, e.rs, e.adr, e.irw, e.pcw,
             e.rw, e.mw, e.ill}) begin
            failures++;
            $display("FAIL %s: got st=%0d aop=%b sa=%b sb=%b rs=%b adr=%b irw=%b pcw=%b rw=%b mw=%b ill=%b ; want st=%0d aop=%b sa=%b sb=%b rs=%b adr=%b irw=%b pcw=%b rw=%b mw=%b ill=%b",
                     tag, state_o, ALUOp, ALUSrcA, ALUSrcB, ResultSrc, AdrSrc, IRWrite, PCWrite,
                     RegWrite, MemWrite, illegal_instr, e.st, e.aop, e.sa, e.sb, e.rs, e.adr,
                     e.irw, e.pcw, e.rw, e.mw, e.ill);
        end
    endtask

    task automatic step(input cyc_t e, input string tag);
        @(posedge clk);
        #1;
        opcode = e.op; zero = e.z; mem_ready = e.mr;
        @(negedge clk);
        check_now(e, tag);
    endtask

    task automatic lit(input string tag, input int got, input int want);
        checks++;
        if (got != want) begin
            failures++;
            $display("FAIL %s: got %0d want %0d", tag, got, want);
        end
    endtask

    task automatic run_instr(input string tag, input logic [6:0] op, input logic z,
                             input int fs, input int ms, input logic ign, input int l_len,
                             input int l_mw, input int l_rw, input int l_pcw, input int l_ill);
        int ret;
        int n;
        ret = -1;
        n_mw = 0; n_rw = 0; n_pcw = 0; n_ill = 0;
        build(op, z, fs, ms, ign);
        n = q.size();
        for (int i = 0; i < n; i++) begin
            step(q[i], tag);
            if (i > fs && state_o == S_FETCH && ret < 0) ret = i;
        end
        // Park in FETCH with mem_ready low so the next instruction starts cleanly.
        step(mk(S_FETCH, 1'b0, z, op), tag);
        if (ret < 0 && state_o == S_FETCH) ret = n;
        lit({tag, "_latency"}, ret, l_len);
        lit({tag, "_memwrite_cycles"}, n_mw, l_mw);
        lit({tag, "_regwrite_cycles"}, n_rw, l_rw);
        lit({tag, "_pcwrite_cycles"}, n_pcw, l_pcw);
        lit({tag, "_illegal_pulses"}, n_ill, l_ill);
    endtask

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

    initial begin
        rst_n = 1'b0; mem_ready = 1'b1; opcode = 7'd0;
        @(negedge clk);
        @(negedge clk);
        lit("reset_state", int'(state_o), int'(S_FETCH));
        lit("reset_strobes", int'({PCWrite, IRWrite, RegWrite, MemWrite, illegal_instr}), 0);
        rst_n = 1'b1;
        #1;
        lit("release_fetch_strobes", int'({IRWrite, PCWrite}), 3);
        mem_ready = 1'b0;

        //         tag      opcode        z     fs ms ign len mw rw pcw ill
        run_instr("add",   7'b0110011, 1'b0, 0, 0, 1'b1, 4, 0, 1, 1, 0);
        run_instr("lw_st", 7'b0000011, 1'b0, 0, 2, 1'b1, 7, 0, 1, 1, 0);
        run_instr("lw",    7'b0000011, 1'b1, 0, 0, 1'b0, 5, 0, 1, 1, 0);
        run_instr("sw_st", 7'b0100011, 1'b0, 0, 1, 1'b1, 5, 2, 0, 1, 0);
        run_instr("sw",    7'b0100011, 1'b0, 0, 0, 1'b0, 4, 1, 0, 1, 0);
        run_instr("beq_t", 7'b1100011, 1'b1, 0, 0, 1'b1, 3, 0, 0, 2, 0);
        run_instr("beq_n", 7'b1100011, 1'b0, 0, 0, 1'b0, 3, 0, 0, 1, 0);
        run_instr("ill",   7'b1111111, 1'b1, 0, 0, 1'b1, 2, 0, 0, 1, 1);
        run_instr("addi",  7'b0010011, 1'b0, 2, 0, 1'b0, 6, 0, 1, 1, 0);
        run_instr("jal",   7'b1101111, 1'b0, 0, 0, 1'b1, 4, 0, 1, 2, 0);

        // Reset asserted while a store waits in MEMWRITE.
        build(7'b0100011, 1'b0, 0, 3, 1'b1);
        for (int i = 0; i < 4; i++) step(q[i], "sw_rst");
        #2;
        mem_ready = 1'b1;
        rst_n = 1'b0;
        #1;
        lit("rst_memwrite_drop", int'(MemWrite), 0);
        lit("rst_state_fetch", int'(state_o), int'(S_FETCH));
        lit("rst_strobes_forced", int'({PCWrite, IRWrite, RegWrite, illegal_instr}), 0);
        @(negedge clk);
        mem_ready = 1'b0;
        rst_n = 1'b1;
        run_instr("post_rst", 7'b0110011, 1'b0, 0, 0, 1'b1, 4, 0, 1, 1, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire
